// File: rtl/serial_sum_collector.sv
// Collects LSB-first sum bits from a serial adder into WIDTH-bit words plus carry-out.
// result_valid rises one cycle after the last bit. Bits arriving while a word is held without a handshake are dropped and flagged.
module serial_sum_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             sum_in,
  input  logic             carry_in,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             result_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_count_inc;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_cout;
  logic             w_cout_nxt;
  logic             r_frame_err;
  logic             w_frame_err_nxt;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_first;
  logic             w_start;
  logic             w_take_first;

  // New bit enters at the MSB so the first bit of a frame ends up in bit 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shift = sum_in;
    end else begin : g_wn
      assign w_shift = {sum_in, r_sr[WIDTH-1:1]};
    end
  endgenerate

  // A fresh frame starts from an empty register so no stale partial bits survive.
  assign w_first     = WIDTH'(sum_in) << (WIDTH - 1);
  assign w_start     = bit_valid && frame_start;
  assign w_count_inc = r_count + CW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_sr_nxt        = r_sr;
    w_result_nxt    = r_result;
    w_cout_nxt      = r_cout;
    w_frame_err_nxt = 1'b0;
    w_take_first    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_take_first = 1'b1;
        end else if (bit_valid) begin
          w_frame_err_nxt = 1'b1;
        end
      end
      COLLECT: begin
        if (w_start) begin
          w_take_first    = 1'b1;
          w_frame_err_nxt = 1'b1;
        end else if (bit_valid) begin
          w_sr_nxt    = w_shift;
          w_count_nxt = w_count_inc;
          if (w_count_inc == LAST) begin
            w_result_nxt = w_shift;
            w_cout_nxt   = carry_in;
            w_state_nxt  = HOLD;
          end
        end
      end
      HOLD: begin
        if (result_ready) begin
          if (w_start) begin
            w_take_first = 1'b1;
          end else begin
            w_state_nxt     = IDLE;
            w_count_nxt     = '0;
            w_frame_err_nxt = bit_valid;
          end
        end else if (bit_valid) begin
          w_frame_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase

    if (w_take_first) begin
      w_sr_nxt    = w_first;
      w_count_nxt = CW'(1);
      if (LAST == CW'(1)) begin
        w_result_nxt = w_first;
        w_cout_nxt   = carry_in;
        w_state_nxt  = HOLD;
      end else begin
        w_state_nxt  = COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_sr        <= '0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_sr        <= w_sr_nxt;
      r_result    <= w_result_nxt;
      r_cout      <= w_cout_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign result       = r_result;
  assign cout         = r_cout;
  assign frame_err    = r_frame_err;
  assign result_valid = (r_state == HOLD);
  assign busy         = (r_state == COLLECT);

endmodule
